life_grid_engine: RTL and testbench

Parametrised successor to the fixed 4x4 life array. It holds a WIDTH x HEIGHT Conway grid (rule B3/S23) in registers and advances one generation per `step` request, processing one row per clock. Rows are loaded one at a time through a row-write port, and a registered row-read port feeds the VGA display path. The block also reports generation count, live-cell population, stable and extinct flags.

---
 rtl/life_pkg.sv | 22 ++
 rtl/life_grid_engine_if.sv | 34 +++
 rtl/life_row_next.sv | 48 ++++
 rtl/life_grid_engine.sv | 143 ++++++++++++++
 tb/tb_life_grid_engine.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared state encoding, B3/S23 rule constants and popcount for the life grid engine
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] BIRTH_N    = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  // Sized for the widest legal row (64 columns).
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) s = s + {6'd0, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/life_grid_engine_if.sv
// rtl/life_grid_engine_if.sv - load, step, display-read and status signals of the life grid engine
interface life_grid_engine_if #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int GEN_W  = 16
);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH * HEIGHT + 1);

  logic             load_valid;
  logic [RW-1:0]    load_row;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             step;
  logic             busy;
  logic             done;
  logic [RW-1:0]    rd_row;
  logic [WIDTH-1:0] rd_data;
  logic [GEN_W-1:0] generation;
  logic [PW-1:0]    population;
  logic             stable;
  logic             extinct;

  modport master (
    output load_valid, load_row, load_data, step, rd_row,
    input  load_ready, busy, done, rd_data, generation, population, stable, extinct
  );

  modport slave (
    input  load_valid, load_row, load_data, step, rd_row,
    output load_ready, busy, done, rd_data, generation, population, stable, extinct
  );

endinterface

// File: rtl/life_row_next.sv
// rtl/life_row_next.sv - combinational B3/S23 next row from above/cur/below; column wrap under LIFE_WRAP_EN
module life_row_next
  import life_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] next
);

  // Bit c of the result is the neighbour at column c-1 of v.
  function automatic logic [WIDTH-1:0] from_lower(input logic [WIDTH-1:0] v);
`ifdef LIFE_WRAP_EN
    return {v[WIDTH-2:0], v[WIDTH-1]};
`else
    return {v[WIDTH-2:0], 1'b0};
`endif
  endfunction

  // Bit c of the result is the neighbour at column c+1 of v.
  function automatic logic [WIDTH-1:0] from_upper(input logic [WIDTH-1:0] v);
`ifdef LIFE_WRAP_EN
    return {v[0], v[WIDTH-1:1]};
`else
    return {1'b0, v[WIDTH-1:1]};
`endif
  endfunction

  logic [WIDTH-1:0] al, ar, cl, cr, bl, br;

  assign al = from_lower(above);
  assign ar = from_upper(above);
  assign cl = from_lower(cur);
  assign cr = from_upper(cur);
  assign bl = from_lower(below);
  assign br = from_upper(below);

  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    logic [3:0] n;
    assign n = 4'(al[c]) + 4'(above[c]) + 4'(ar[c])
             + 4'(cl[c]) + 4'(cr[c])
             + 4'(bl[c]) + 4'(below[c]) + 4'(br[c]);
    assign next[c] = (n == BIRTH_N) || (cur[c] && (n >= SURVIVE_LO) && (n <= SURVIVE_HI));
  end

endmodule

// File: rtl/life_grid_engine.sv
// rtl/life_grid_engine.sv - WIDTH x HEIGHT Conway grid, one row per clock per generation; toroidal under LIFE_WRAP_EN
module life_grid_engine
  import life_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int GEN_W  = 16
) (
  input logic              clk,
  input logic              reset,
  life_grid_engine_if.slave bus
);

  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH * HEIGHT + 1);
  localparam logic [RW:0]   ROWS = HEIGHT[RW:0];
  localparam logic [RW-1:0] LAST = RW'(HEIGHT - 1);
`ifdef LIFE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t state, state_nx;

  logic [WIDTH-1:0] grid [HEIGHT];
  logic [RW-1:0]    row;
  logic [WIDTH-1:0] first_row, prev_old;
  logic [WIDTH-1:0] cur_row, below_row, next_row;
  logic [WIDTH-1:0] row0_eff, rowl_eff;
  logic [PW-1:0]    acc, acc_sum;
  logic             change, change_sum;
  logic             load_ok, step_ok, last_row;

  logic [WIDTH-1:0] rd_q;
  logic [GEN_W-1:0] gen_q;
  logic [PW-1:0]    pop_q;
  logic             stable_q, extinct_q;

  assign load_ok  = bus.load_valid && (state == IDLE) && ({1'b0, bus.load_row} < ROWS);
  assign step_ok  = bus.step && (state == IDLE);
  assign last_row = (row == LAST);

  assign cur_row   = grid[row];
  assign below_row = last_row ? first_row : grid[row + RW'(1)];

  // A load in the same cycle as the step must be seen by the wrap-around rows.
  assign row0_eff = (load_ok && bus.load_row == '0)   ? bus.load_data : grid[0];
  assign rowl_eff = (load_ok && bus.load_row == LAST) ? bus.load_data : grid[LAST];

  life_row_next #(.WIDTH(WIDTH)) u_row_next (
    .above (prev_old),
    .cur   (cur_row),
    .below (below_row),
    .next  (next_row)
  );

  assign acc_sum    = acc + PW'(popcount(64'(next_row)));
  assign change_sum = change | (next_row != cur_row);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.busy       = 1'b0;
    bus.load_ready = 1'b0;
    bus.done       = 1'b0;
    case (state)
      IDLE: begin
        bus.load_ready = 1'b1;
        if (bus.step) state_nx = STEP;
      end
      STEP: begin
        bus.busy = 1'b1;
        if (last_row) state_nx = FIN;
      end
      FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HEIGHT; i++) grid[i] <= '0;
      row       <= '0;
      first_row <= '0;
      prev_old  <= '0;
      acc       <= '0;
      change    <= 1'b0;
      rd_q      <= '0;
      gen_q     <= '0;
      pop_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      rd_q <= ({1'b0, bus.rd_row} < ROWS) ? grid[bus.rd_row] : '0;

      if (load_ok) begin
        grid[bus.load_row] <= bus.load_data;
        gen_q     <= '0;
        stable_q  <= 1'b0;
        extinct_q <= 1'b0;
      end

      if (step_ok) begin
        row       <= '0;
        first_row <= WRAP ? row0_eff : '0;
        prev_old  <= WRAP ? rowl_eff : '0;
        acc       <= '0;
        change    <= 1'b0;
      end

      if (state == STEP) begin
        grid[row] <= next_row;
        prev_old  <= cur_row;
        row       <= row + RW'(1);
        acc       <= acc_sum;
        change    <= change_sum;
        // Status is committed with the last row so it is already valid while done is high.
        if (last_row) begin
          pop_q     <= acc_sum;
          extinct_q <= (acc_sum == '0);
          stable_q  <= !change_sum;
          gen_q     <= gen_q + GEN_W'(1);
        end
      end
    end
  end

  assign bus.rd_data    = rd_q;
  assign bus.generation = gen_q;
  assign bus.population = pop_q;
  assign bus.stable     = stable_q;
  assign bus.extinct    = extinct_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// tb/tb_life_grid_engine.sv - directed and random generation checks of life_grid_engine against a cell-level model
module tb_life_grid_engine;

  localparam int W = 16;
  localparam int H = 16;
  localparam int G = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  life_grid_engine_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(G)) bus ();

  life_grid_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mg [H];
  int m_gen, m_pop;
  bit m_stable, m_ext;
  logic [W-1:0] rdv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] nx [H];
    int pop, n, rr, cc;
    pop = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
`ifdef LIFE_WRAP_EN
            rr = (rr + H) % H;
            cc = (cc + W) % W;
`else
            if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
`endif
            n += int'(mg[rr][cc]);
          end
        end
        nx[r][c] = (n == 3) || (mg[r][c] && n == 2);
        pop += int'(nx[r][c]);
      end
    end
    m_stable = 1'b1;
    for (int r = 0; r < H; r++) if (nx[r] != mg[r]) m_stable = 1'b0;
    for (int r = 0; r < H; r++) mg[r] = nx[r];
    m_pop = pop;
    m_ext = (pop == 0);
    m_gen = (m_gen + 1) % (1 << G);
  endtask

  task automatic do_load(input int r, input logic [W-1:0] d);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_row   = r[3:0];
    bus.load_data  = d;
    @(negedge clk);
    bus.load_valid = 1'b0;
    mg[r] = d;
    m_gen = 0;
    m_stable = 1'b0;
    m_ext = 1'b0;
  endtask

  task automatic clear_grid();
    for (int r = 0; r < H; r++) do_load(r, '0);
  endtask

  task automatic read_row(input int r, output logic [W-1:0] d);
    @(negedge clk);
    bus.rd_row = r[3:0];
    @(posedge clk);
    #1;
    d = bus.rd_data;
  endtask

  task automatic check_grid(input string tag);
    logic [W-1:0] d;
    for (int r = 0; r < H; r++) begin
      read_row(r, d);
      check($sformatf("%s_row%0d", tag, r), d, mg[r]);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_gen"},     bus.generation, m_gen);
    check({tag, "_pop"},     bus.population, m_pop);
    check({tag, "_stable"},  bus.stable,     m_stable);
    check({tag, "_extinct"}, bus.extinct,    m_ext);
  endtask

  // inject: fire an ignored step and load mid-generation; with_load: load and step together.
  task automatic do_step(input bit inject, input bit with_load, input int lrow, input logic [W-1:0] ldata);
    int n;
    bit seen;
    @(negedge clk);
    bus.step = 1'b1;
    if (with_load) begin
      bus.load_valid = 1'b1;
      bus.load_row   = lrow[3:0];
      bus.load_data  = ldata;
      mg[lrow] = ldata;
      m_gen = 0;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      bus.step = 1'b0;
      bus.load_valid = 1'b0;
      if (inject && n == 4) begin
        check("busy_mid", bus.busy, 1'b1);
        check("ready_mid", bus.load_ready, 1'b0);
        @(negedge clk);
        bus.step       = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_row   = lrow[3:0];
        bus.load_data  = ldata;
      end
      seen = bus.done;
    end
    check("done_latency", n, H + 1);
    model_step();
    check_status("step");
    @(posedge clk);
    #1;
    check("busy_after", bus.busy, 1'b0);
    check("ready_after", bus.load_ready, 1'b1);
    check("done_after", bus.done, 1'b0);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_row   = '0;
    bus.load_data  = '0;
    bus.step       = 1'b0;
    bus.rd_row     = '0;
    m_gen = 0; m_pop = 0; m_stable = 1'b0; m_ext = 1'b0;
    for (int r = 0; r < H; r++) mg[r] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.load_ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_gen", bus.generation, 0);
    check("rst_pop", bus.population, 0);
    check("rst_rd", bus.rd_data, 0);
    reset = 1'b1;
    check_grid("rst0");

    // Blinker
    do_load(7, 16'h0380);
    do_step(1'b0, 1'b0, 0, '0);
    check_grid("blink1");
    read_row(6, rdv); check("blink1_r6", rdv, 16'h0100);
    read_row(7, rdv); check("blink1_r7", rdv, 16'h0100);
    read_row(8, rdv); check("blink1_r8", rdv, 16'h0100);
    check("blink1_pop", bus.population, 3);
    check("blink1_gen", bus.generation, 1);
    check("blink1_stable", bus.stable, 1'b0);
    do_step(1'b0, 1'b0, 0, '0);
    read_row(7, rdv); check("blink2_r7", rdv, 16'h0380);
    check("blink2_gen", bus.generation, 2);

    // Block
    clear_grid();
    do_load(4, 16'h0180);
    do_load(5, 16'h0180);
    do_step(1'b0, 1'b0, 0, '0);
    check_grid("block");
    check("block_stable", bus.stable, 1'b1);
    check("block_pop", bus.population, 4);
    check("block_extinct", bus.extinct, 1'b0);

    // Edge columns
    clear_grid();
    do_load(0, 16'h8003);
    do_step(1'b0, 1'b0, 0, '0);
    check_grid("edge");
`ifdef LIFE_WRAP_EN
    read_row(15, rdv); check("edge_r15", rdv, 16'h0001);
    read_row(0, rdv);  check("edge_r0", rdv, 16'h0001);
    read_row(1, rdv);  check("edge_r1", rdv, 16'h0001);
    check("edge_pop", bus.population, 3);
`else
    check("edge_pop", bus.population, 0);
    check("edge_extinct", bus.extinct, 1'b1);
`endif

    // Lone cell dies, then the empty grid is stable
    clear_grid();
    do_load(3, 16'h0010);
    do_step(1'b0, 1'b0, 0, '0);
    check("single_pop", bus.population, 0);
    check("single_extinct", bus.extinct, 1'b1);
    check("single_stable", bus.stable, 1'b0);
    do_step(1'b0, 1'b0, 0, '0);
    check("single2_stable", bus.stable, 1'b1);

    // Step and load while busy are ignored
    clear_grid();
    do_load(7, 16'h0380);
    do_step(1'b1, 1'b0, 5, 16'hFFFF);
    check_grid("inject");
    check("inject_gen", bus.generation, 1);

    // Load and step in the same cycle
    do_step(1'b0, 1'b1, 7, 16'h0380);
    check_grid("same_cycle");
    check("same_cycle_gen", bus.generation, 1);

    // Random grids
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < H; r++) do_load(r, 16'($urandom));
      repeat (3) do_step(1'b0, 1'b0, 0, '0);
      check_grid($sformatf("rand%0d", it));
    end

    // Reset in the middle of a generation
    @(negedge clk);
    bus.step = 1'b1;
    @(posedge clk);
    #1;
    bus.step = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstmid_busy", bus.busy, 1'b0);
    check("rstmid_done", bus.done, 1'b0);
    check("rstmid_ready", bus.load_ready, 1'b1);
    check("rstmid_gen", bus.generation, 0);
    check("rstmid_pop", bus.population, 0);
    check("rstmid_stable", bus.stable, 1'b0);
    check("rstmid_extinct", bus.extinct, 1'b0);
    check("rstmid_rd", bus.rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < H; r++) mg[r] = '0;
    check_grid("rstmid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
